// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a host controller and the PS/2 transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits + odd parity + stop,
// then checks the device acknowledge. Lines are driven through active-low output enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_HOLD     = 16,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe,
    output logic         busy,
    output logic         done,
    output logic         nack,
    output logic         timeout
);
    localparam int TMAX1 = (INHIBIT_CYCLES > START_HOLD) ? INHIBIT_CYCLES : START_HOLD;
    localparam int TMAX  = (TIMEOUT_CYCLES > TMAX1) ? TIMEOUT_CYCLES : TMAX1;
    localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_STOP, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [3:0]    bit_cnt, bit_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          parity_q, parity_d;
    logic          data_oe_q, data_oe_d;
    logic          nack_q, nack_d;
    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev;
    logic          fall;
    logic          timer_expired;
    logic          abort;

    // Synchronisers idle high so leaving reset never fakes a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall          = clk_prev & ~clk_sync[1];
    assign timer_expired = (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            data_oe_q <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            state     <= state_d;
            timer     <= timer_d;
            bit_cnt   <= bit_cnt_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            data_oe_q <= data_oe_d;
            nack_q    <= nack_d;
        end
    end

    always_comb begin
        state_d   = state;
        timer_d   = timer + 1'b1;
        bit_cnt_d = bit_cnt;
        data_d    = data_q;
        parity_d  = parity_q;
        data_oe_d = data_oe_q;
        nack_d    = nack_q;
        done      = 1'b0;
        nack      = 1'b0;
        timeout   = 1'b0;
        abort     = 1'b0;

        case (state)
            S_IDLE: begin
                timer_d = '0;
                if (tx.tx_valid) begin
                    data_d    = tx.tx_data;
                    parity_d  = ~^tx.tx_data;
                    bit_cnt_d = '0;
                    data_oe_d = 1'b0;
                    nack_d    = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (timer == TW'(INHIBIT_CYCLES - 1)) begin
                    timer_d   = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (timer == TW'(START_HOLD - 1)) begin
                    timer_d = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (fall) begin
                    timer_d = '0;
                    if (bit_cnt == 4'd8) begin
                        data_oe_d = ~parity_q;
                        state_d   = S_STOP;
                    end else begin
                        data_oe_d = ~data_q[bit_cnt[2:0]];
                        bit_cnt_d = bit_cnt + 4'd1;
                    end
                end else if (timer_expired) begin
                    abort = 1'b1;
                end
            end
            S_STOP: begin
                if (fall) begin
                    timer_d   = '0;
                    data_oe_d = 1'b0;
                    state_d   = S_ACK;
                end else if (timer_expired) begin
                    abort = 1'b1;
                end
            end
            S_ACK: begin
                if (fall) begin
                    timer_d = '0;
                    nack_d  = data_sync[1];
                    state_d = S_WAIT_IDLE;
                end else if (timer_expired) begin
                    abort = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_sync[1] && data_sync[1]) begin
                    done    = 1'b1;
                    nack    = nack_q;
                    timer_d = '0;
                    state_d = S_IDLE;
                end else if (fall) begin
                    timer_d = '0;
                end else if (timer_expired) begin
                    abort = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A silent device ends the transfer with the lines released.
        if (abort) begin
            done      = 1'b1;
            timeout   = 1'b1;
            data_oe_d = 1'b0;
            timer_d   = '0;
            state_d   = S_IDLE;
        end
    end

    assign tx.tx_ready  = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign ps2_clk_oe   = (state == S_INHIBIT) || (state == S_REQ);
    assign ps2_data_oe  = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks the frame out and a scoreboard
// of expected frames/results is compared against what the device and done pulse report.
module tb_ps2_host_tx;
    localparam int INH  = 20;
    localparam int SH   = 4;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    typedef struct {
        logic [10:0] frame;
        logic        nack;
        logic        to;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic ps2_clk_oe, ps2_data_oe, busy, done, nack, timeout;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    wire  clk_line  = ~(ps2_clk_oe | dev_clk_low);
    wire  data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx_if tx_bus();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_HOLD(SH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tx(tx_bus),
        .ps2_clk_in(clk_line),
        .ps2_data_in(data_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy(busy),
        .done(done),
        .nack(nack),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int oe_high_cnt = 0;
    int done_cnt = 0;
    int accept_cnt = 0;
    int last_accept_cycle = -1;
    int reset_cnt = 0;
    int dev_edges = 11;
    logic dev_ack = 1'b1;
    int dev_falls = 0;
    int last_pin_fall = 0;
    logic [10:0] got_frame = '0;
    int got_frame_cnt = 0;
    exp_t exp_q[$];

    always @(posedge clk) cycle <= cycle + 1;
    always @(posedge reset) reset_cnt <= reset_cnt + 1;

    always @(negedge clk) begin
        if (ps2_clk_oe) oe_high_cnt <= oe_high_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (tx_bus.tx_valid && tx_bus.tx_ready) begin
            last_accept_cycle <= cycle;
            accept_cnt        <= accept_cnt + 1;
        end
    end

    // Device model: waits for the host to release the clock with data low, then clocks
    // 11 bits at a 40-cycle period, sampling on rising edges and acknowledging on request.
    initial begin : device
        logic [10:0] fr;
        int rst_snap;
        bit aborted;
        forever begin
            @(posedge clk);
            while (!ps2_clk_oe) @(posedge clk);
            while (ps2_clk_oe) @(posedge clk);
            if (busy && ps2_data_oe) begin
                rst_snap = reset_cnt;
                aborted  = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                fr    = '0;
                fr[0] = data_line;
                for (int k = 1; k <= dev_edges && !aborted; k++) begin
                    dev_clk_low   = 1'b1;
                    dev_falls     = dev_falls + 1;
                    last_pin_fall = cycle;
                    repeat (HALF) @(posedge clk);
                    #1;
                    dev_clk_low = 1'b0;
                    if (reset_cnt != rst_snap) begin
                        aborted = 1'b1;
                    end else begin
                        if (k <= 10) fr[k] = data_line;
                        if (k == 10) begin
                            got_frame     = fr;
                            got_frame_cnt = got_frame_cnt + 1;
                            if (dev_ack) dev_data_low = 1'b1;
                        end
                        if (k == 11) dev_data_low = 1'b0;
                        if (k < dev_edges) begin
                            repeat (HALF) @(posedge clk);
                            #1;
                            if (reset_cnt != rst_snap) aborted = 1'b1;
                        end
                    end
                end
                dev_data_low = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic ack, input int edges,
                             input logic exp_nack, input logic exp_to);
        int budget = 200;
        dev_ack   = ack;
        dev_edges = edges;
        while (!tx_bus.tx_ready && budget > 0) begin
            step(1);
            budget--;
        end
        if (!tx_bus.tx_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_ready: tx_ready=%b required 1", tx_bus.tx_ready);
        end
        tx_bus.tx_data  = d;
        tx_bus.tx_valid = 1'b1;
        step(1);
        tx_bus.tx_valid = 1'b0;
        exp_q.push_back('{frame: {1'b1, ~^d, d, 1'b0}, nack: exp_nack, to: exp_to});
    endtask

    task automatic await_done(input string name, input int budget,
                              output logic got_nack, output logic got_to, output int done_cycle);
        got_nack   = 1'bx;
        got_to     = 1'bx;
        done_cycle = -1;
        while (!done && budget > 0) begin
            step(1);
            budget--;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: done=%b required 1 within budget", name, done);
        end else begin
            got_nack   = nack;
            got_to     = timeout;
            done_cycle = cycle;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(3);
        checks++; if (tx_bus.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready: got %b required 1", tx_bus.tx_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b required 0", busy); end
        checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("[TB] FAIL rst_clk_oe: got %b required 0", ps2_clk_oe); end
        checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL rst_data_oe: got %b required 0", ps2_data_oe); end
        checks++; if ({done, nack, timeout} !== 3'b000) begin errors++; $display("[TB] FAIL rst_status: got %b required 000", {done, nack, timeout}); end
        reset = 1'b0;
        step(5);
    endtask

    task automatic test_send_ack;
        exp_t e;
        logic gn, gt;
        int dc;
        int oe0 = oe_high_cnt;
        int fc0 = got_frame_cnt;
        send_byte(8'hF4, 1'b1, 11, 1'b0, 1'b0);
        await_done("f4_done", 1500, gn, gt, dc);
        e = exp_q.pop_front();
        checks++; if (gn !== e.nack) begin errors++; $display("[TB] FAIL f4_nack: got %b required %b", gn, e.nack); end
        checks++; if (gt !== e.to) begin errors++; $display("[TB] FAIL f4_timeout: got %b required %b", gt, e.to); end
        checks++; if (got_frame_cnt != fc0 + 1 || got_frame !== e.frame) begin errors++; $display("[TB] FAIL f4_frame: got %b required %b", got_frame, e.frame); end
        checks++; if (got_frame[9] !== 1'b0) begin errors++; $display("[TB] FAIL f4_parity: got %b required 0", got_frame[9]); end
        checks++; if (oe_high_cnt - oe0 != INH + SH) begin errors++; $display("[TB] FAIL f4_clk_oe_len: got %0d required %0d", oe_high_cnt - oe0, INH + SH); end
        step(1);
        checks++; if (done !== 1'b0 || tx_bus.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL f4_after: done=%b ready=%b required 0/1", done, tx_bus.tx_ready); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic gn, gt;
        int dc, dc2;
        int dn0 = done_cnt;
        send_byte(8'hED, 1'b1, 11, 1'b0, 1'b0);
        await_done("ed_done", 1500, gn, gt, dc);
        tx_bus.tx_data  = 8'h07;
        tx_bus.tx_valid = 1'b1;
        exp_q.push_back('{frame: {1'b1, ~^8'h07, 8'h07, 1'b0}, nack: 1'b0, to: 1'b0});
        e = exp_q.pop_front();
        checks++; if (gn !== e.nack || gt !== e.to) begin errors++; $display("[TB] FAIL ed_result: got %b%b required %b%b", gn, gt, e.nack, e.to); end
        checks++; if (got_frame !== e.frame || got_frame[9] !== 1'b1) begin errors++; $display("[TB] FAIL ed_frame: got %b required %b", got_frame, e.frame); end
        step(1);
        checks++; if (tx_bus.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready: got %b required 1", tx_bus.tx_ready); end
        step(1);
        tx_bus.tx_valid = 1'b0;
        checks++; if (last_accept_cycle != dc + 1) begin errors++; $display("[TB] FAIL b2b_accept_cycle: got %0d required %0d", last_accept_cycle, dc + 1); end
        await_done("07_done", 1500, gn, gt, dc2);
        e = exp_q.pop_front();
        checks++; if (gn !== e.nack || gt !== e.to) begin errors++; $display("[TB] FAIL 07_result: got %b%b required %b%b", gn, gt, e.nack, e.to); end
        checks++; if (got_frame !== e.frame || got_frame[9] !== 1'b0) begin errors++; $display("[TB] FAIL 07_frame: got %b required %b", got_frame, e.frame); end
        step(1);
        checks++; if (done_cnt - dn0 != 2) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d required 2", done_cnt - dn0); end
    endtask

    task automatic test_nack;
        exp_t e;
        logic gn, gt;
        int dc;
        send_byte(8'h00, 1'b0, 11, 1'b1, 1'b0);
        await_done("nack_done", 1500, gn, gt, dc);
        e = exp_q.pop_front();
        checks++; if (gn !== 1'b1 || gn !== e.nack) begin errors++; $display("[TB] FAIL nack_flag: got %b required 1", gn); end
        checks++; if (gt !== e.to) begin errors++; $display("[TB] FAIL nack_timeout: got %b required %b", gt, e.to); end
        checks++; if (got_frame !== e.frame || got_frame[9] !== 1'b1) begin errors++; $display("[TB] FAIL nack_frame: got %b required %b", got_frame, e.frame); end
        step(1);
    endtask

    task automatic test_timeout;
        exp_t e;
        logic gn, gt;
        int dc;
        int fc0 = got_frame_cnt;
        send_byte(8'h5A, 1'b1, 4, 1'b0, 1'b1);
        await_done("to_done", 3000, gn, gt, dc);
        e = exp_q.pop_front();
        checks++; if (gt !== e.to) begin errors++; $display("[TB] FAIL to_flag: got %b required %b", gt, e.to); end
        checks++; if (gn !== e.nack) begin errors++; $display("[TB] FAIL to_nack: got %b required %b", gn, e.nack); end
        checks++; if (dc != last_pin_fall + 2 + TO) begin errors++; $display("[TB] FAIL to_cycle: got %0d required %0d", dc, last_pin_fall + 2 + TO); end
        checks++; if (got_frame_cnt != fc0) begin errors++; $display("[TB] FAIL to_no_frame: got %0d frames required 0", got_frame_cnt - fc0); end
        step(1);
        checks++; if ({ps2_clk_oe, ps2_data_oe, tx_bus.tx_ready, done} !== 4'b0010) begin errors++; $display("[TB] FAIL to_after: got %b required 0010", {ps2_clk_oe, ps2_data_oe, tx_bus.tx_ready, done}); end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        logic gn, gt;
        int dc;
        int budget = 800;
        int f0 = dev_falls;
        int dn0 = done_cnt;
        send_byte(8'h35, 1'b1, 11, 1'b0, 1'b0);
        while (dev_falls < f0 + 4 && budget > 0) begin
            step(1);
            budget--;
        end
        step(10);
        checks++; if (ps2_data_oe !== 1'b1) begin errors++; $display("[TB] FAIL mid_bit3: data_oe=%b required 1", ps2_data_oe); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL mid_release: oe=%b%b required 00", ps2_clk_oe, ps2_data_oe); end
        step(5);
        reset = 1'b0;
        e = exp_q.pop_front();
        step(30);
        checks++; if (done_cnt != dn0) begin errors++; $display("[TB] FAIL mid_no_done: got %0d pulses required 0", done_cnt - dn0); end
        checks++; if (tx_bus.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready: got %b required 1", tx_bus.tx_ready); end
        send_byte(8'hFF, 1'b1, 11, 1'b0, 1'b0);
        await_done("ff_done", 1500, gn, gt, dc);
        e = exp_q.pop_front();
        checks++; if (gn !== e.nack || gt !== e.to) begin errors++; $display("[TB] FAIL ff_result: got %b%b required %b%b", gn, gt, e.nack, e.to); end
        checks++; if (got_frame !== e.frame || got_frame[9] !== 1'b1) begin errors++; $display("[TB] FAIL ff_frame: got %b required %b", got_frame, e.frame); end
        step(1);
    endtask

    task automatic test_busy_ignore;
        exp_t e;
        logic gn, gt;
        int dc;
        int ac0 = accept_cnt;
        send_byte(8'h96, 1'b1, 11, 1'b0, 1'b0);
        step(5);
        tx_bus.tx_data  = 8'hAA;
        tx_bus.tx_valid = 1'b1;
        checks++; if (tx_bus.tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL busy_ready: got %b required 0", tx_bus.tx_ready); end
        step(1);
        tx_bus.tx_valid = 1'b0;
        await_done("busy_done", 1500, gn, gt, dc);
        e = exp_q.pop_front();
        checks++; if (got_frame !== e.frame) begin errors++; $display("[TB] FAIL busy_frame: got %b required %b", got_frame, e.frame); end
        checks++; if (gn !== e.nack || gt !== e.to) begin errors++; $display("[TB] FAIL busy_result: got %b%b required %b%b", gn, gt, e.nack, e.to); end
        step(2);
        checks++; if (accept_cnt - ac0 != 1) begin errors++; $display("[TB] FAIL busy_accepts: got %0d required 1", accept_cnt - ac0); end
    endtask

    initial begin
        tx_bus.tx_data  = 8'h00;
        tx_bus.tx_valid = 1'b0;
        test_reset();
        test_send_ack();
        test_back_to_back();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_busy_ignore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the send-side counterpart of the keyboard scan-code receiver.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) using the PS/2 request-to-send protocol, then checks the device acknowledge.
- Runs on the system clock and drives the open-drain PS/2 clock and data lines through active-low output enables.
- While `busy`=1, the scan-code receiver output is invalid and must be ignored.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles to hold ps2_clk low before the request (100 us at 50 MHz).
- START_HOLD, 16, clk cycles with ps2_clk and ps2_data both low before ps2_clk is released.
- TIMEOUT_CYCLES, 750000, maximum clk cycles between device clock falling edges, or to the final idle (15 ms at 50 MHz).

Ports:
- clk  input  1  system clock (10-50 MHz).
- reset  input  1  asynchronous, active-high reset.
- tx_data  input  8  command byte.
- tx_valid  input  1  request to send tx_data.
- tx_ready  output  1  high only in IDLE; a byte is accepted when tx_valid & tx_ready.
- ps2_clk_in  input  1  PS/2 clock line as sensed (asynchronous).
- ps2_data_in  input  1  PS/2 data line as sensed (asynchronous).
- ps2_clk_oe  output  1  1 = pull PS/2 clock low; 0 = release.
- ps2_data_oe  output  1  1 = pull PS/2 data low; 0 = release.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of a transfer, including error endings.
- nack  output  1  valid with done: 1 = device did not acknowledge.
- timeout  output  1  valid with done: 1 = transfer aborted by timeout.

Behaviour:
Reset:
- State IDLE; all outputs 0 except tx_ready=1; both lines released; counters cleared.
- Reset mid-transfer releases both lines immediately (asynchronous), with no done pulse.

Input synchronisation and edge detection:
- ps2_clk_in and ps2_data_in each pass through a 2-flop synchroniser.
- A falling edge `fall` is flagged when the previous synchronised clock value is 1 and the current value is 0.
- `fall` is asserted 3 clk cycles after the pin transition at most.

Accept:
- On accept, latch tx_data and compute parity = ~^tx_data (odd parity).
- Clear bit_cnt and the timer; go to INHIBIT.

States (oe values given as clk_oe/data_oe):
- IDLE (0/0): wait for accept.
- INHIBIT (1/0): stay exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ (1/1): stay exactly START_HOLD cycles, then go to SEND. This drives the start bit.
- SEND (0/x):
  - On each fall, with bit_cnt k = 0..7: data_oe = ~tx_data[k], applied the cycle after fall.
  - After bit 7, the next fall drives data_oe = ~parity and moves to STOP.
- STOP:
  - On fall, data_oe = 0 (stop bit = 1, line released); go to ACK.
- ACK:
  - On fall, sample synchronised data: 0 = ACK, 1 = NACK; store the result; go to WAIT_IDLE.
- WAIT_IDLE (0/0):
  - Wait until synchronised clk = 1 and data = 1.
  - Then pulse done with the stored nack; go to IDLE.

Timeout:
- The timer clears on entry to SEND and on every fall.
- In SEND, STOP, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES causes:
  - both oe = 0,
  - done = 1 and timeout = 1 for one cycle (nack = 0),
  - return to IDLE.

Boundaries:
- tx_valid while busy is ignored; tx_ready = 0.
- A fall seen during INHIBIT or REQ is ignored; the host owns the clock in those states.
- The done pulse occurs in the same cycle as the transition to IDLE; tx_ready rises in the following cycle.
- Back-to-back sends: a new accept is possible the cycle after done.
- Timer widths are $clog2 of the corresponding parameter.

Test Plan:
- All tests use INHIBIT_CYCLES=20, START_HOLD=4, TIMEOUT_CYCLES=2000, and a device model with a clock period of 40 cycles.
- Send 0xF4, device ACKs -> device samples start 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1; ps2_clk_oe high exactly 24 cycles; done=1, nack=0, timeout=0; tx_ready back to 1.
- Send 0xED then 0x07 back-to-back -> parity bits 1 then 0; two done pulses, both nack=0; second accept occurs the cycle after the first done.
- Device holds data high at the ACK edge for 0x00 -> parity 1; done=1, nack=1.
- Device stops clocking after 4 edges -> exactly 2000 cycles after the last fall: done=1, timeout=1, both oe=0, state IDLE.
- Assert reset during SEND at bit 3 -> both oe drop the same cycle, no done pulse, tx_ready=1 after reset release; a following 0xFF send completes with parity 1 and an ACK.
- Pulse tx_valid with 0xAA while busy -> ignored; the in-flight byte transmits unchanged.
